// File: rtl/can_pkg.sv
// can_pkg: shared definitions for the CAN receive front end.
//   - FSM state encoding of can_rx_bit_sampler
//   - CAN bus level constants
//   - default parameter values (synchroniser depth, idle length, stuff length)
package can_pkg;

  typedef enum logic [1:0] {
    ST_INTEG = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SOF   = 2'd2,
    ST_RECV  = 2'd3
  } can_rx_state_e;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

  localparam int CAN_SYNC_STAGES_DEF = 2;
  localparam int CAN_IDLE_BITS_DEF   = 11;
  localparam int CAN_STUFF_LEN_DEF   = 5;

endpackage

// File: rtl/can_rx_sync.sv
// can_rx_sync: brings the asynchronous CAN RX pin into clk_i and flags its
// falling (recessive -> dominant) edges.
// Ports:
//   clk_i    in   system clock
//   rst_i    in   asynchronous active-high reset (flops preset to recessive)
//   rx_i     in   raw CAN RX pin
//   rx_s_o   out  synchronised RX level
//   fall_o   out  one-cycle flag: rx_s_o went 1 -> 0 this cycle
module can_rx_sync
  import can_pkg::*;
#(
  parameter int SYNC_STAGES = CAN_SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{CAN_RECESSIVE}};
      rx_s_q <= CAN_RECESSIVE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_s_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s_o = sync_q[SYNC_STAGES-1];
  assign fall_o = rx_s_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/can_rx_bit_sampler.sv
// can_rx_bit_sampler: CAN receive front end. Synchronises the RX pin, samples
// it at the falling edge of the bit clock, hard-syncs the bit-clock generator
// on the SOF edge, detects bus idle, removes stuff bits and flags stuff errors.
// Optional build macro: CAN_RX_RESYNC_EN -- in RECV, every RX falling edge not
// coincident with a sample point also pulses sync_o (edge resynchronisation).
// Ports:
//   clk_i         in   system clock
//   rst_i         in   asynchronous active-high reset
//   can_rx_i      in   raw CAN RX pin (1 = recessive)
//   can_clk_i     in   bit clock; falling edge = sample point
//   destuff_en_i  in   destuffing / stuff check enable from MAC
//   rx_done_i     in   frame finished, return to integrating
//   sync_o        out  restart bit timing pulse
//   bit_o         out  destuffed data bit
//   bit_valid_o   out  bit_o valid strobe
//   sof_o         out  start-of-frame strobe
//   stuff_err_o   out  stuff rule violation strobe
//   idle_o        out  bus idle
//
// state | meaning
// INTEG | counting consecutive recessive samples to find bus idle
// IDLE  | bus idle, waiting for the SOF falling edge
// SOF   | hard-synced, waiting for the SOF sample point to confirm dominant
// RECV  | receiving frame bits, destuffing while destuff_en_i is high
module can_rx_bit_sampler
  import can_pkg::*;
#(
  parameter int SYNC_STAGES = CAN_SYNC_STAGES_DEF,
  parameter int IDLE_BITS   = CAN_IDLE_BITS_DEF,
  parameter int STUFF_LEN   = CAN_STUFF_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic can_rx_i,
  input  logic can_clk_i,
  input  logic destuff_en_i,
  input  logic rx_done_i,
  output logic sync_o,
  output logic bit_o,
  output logic bit_valid_o,
  output logic sof_o,
  output logic stuff_err_o,
  output logic idle_o
);

  localparam int IDLE_W = $clog2(IDLE_BITS + 1);
  localparam int RUN_W  = $clog2(STUFF_LEN + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_BITS);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);

  logic rx_s;
  logic fall_rx;
  logic samp;

  can_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx_i  (can_rx_i),
    .rx_s_o(rx_s),
    .fall_o(fall_rx)
  );

  can_rx_state_e     state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              run_val_q, run_val_d;
  logic              can_clk_q;
  logic              sync_q, sync_d;
  logic              bit_q, bit_d;
  logic              bit_valid_q, bit_valid_d;
  logic              sof_q, sof_d;
  logic              stuff_err_q, stuff_err_d;
  logic              idle_q, idle_d;

  assign samp = can_clk_q & ~can_clk_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_INTEG;
      idle_cnt_q  <= '0;
      run_cnt_q   <= '0;
      run_val_q   <= 1'b0;
      can_clk_q   <= 1'b0;
      sync_q      <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      stuff_err_q <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      run_cnt_q   <= run_cnt_d;
      run_val_q   <= run_val_d;
      can_clk_q   <= can_clk_i;
      sync_q      <= sync_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      sof_q       <= sof_d;
      stuff_err_q <= stuff_err_d;
      idle_q      <= idle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    run_cnt_d   = run_cnt_q;
    run_val_d   = run_val_q;
    sync_d      = 1'b0;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    sof_d       = 1'b0;
    stuff_err_d = 1'b0;

    unique case (state_q)
      ST_INTEG: begin
        if (samp) begin
          if (rx_s == CAN_RECESSIVE) begin
            // saturating count: never wraps back below IDLE_BITS
            idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? IDLE_MAX : idle_cnt_q + IDLE_W'(1);
            if (idle_cnt_d == IDLE_MAX) state_d = ST_IDLE;
          end else begin
            idle_cnt_d = '0;
          end
        end
      end

      ST_IDLE: begin
        // a sample point coinciding with the SOF edge is deliberately ignored
        if (fall_rx) begin
          sync_d  = 1'b1;
          state_d = ST_SOF;
        end
      end

      ST_SOF: begin
        if (samp) begin
          if (rx_s == CAN_DOMINANT) begin
            sof_d     = 1'b1;
            run_val_d = CAN_DOMINANT;
            run_cnt_d = RUN_ONE;
            state_d   = ST_RECV;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RECV: begin
`ifdef CAN_RX_RESYNC_EN
        if (fall_rx && !samp) sync_d = 1'b1;
`endif
        if (rx_done_i) begin
          // frame end wins over a coincident sample; that sample is dropped
          state_d    = ST_INTEG;
          idle_cnt_d = '0;
        end else if (samp) begin
          if (destuff_en_i) begin
            if (run_cnt_q == RUN_MAX) begin
              if (rx_s != run_val_q) begin
                run_val_d = rx_s;
                run_cnt_d = RUN_ONE;
              end else begin
                stuff_err_d = 1'b1;
                state_d     = ST_INTEG;
                idle_cnt_d  = '0;
              end
            end else begin
              bit_d       = rx_s;
              bit_valid_d = 1'b1;
              run_cnt_d   = (rx_s == run_val_q) ? run_cnt_q + RUN_ONE : RUN_ONE;
              run_val_d   = rx_s;
            end
          end else begin
            bit_d       = rx_s;
            bit_valid_d = 1'b1;
            run_cnt_d   = RUN_ONE;
            run_val_d   = rx_s;
          end
        end
      end

      default: state_d = ST_INTEG;
    endcase

    // registered from the next state so idle drops in the same cycle as sync_o
    idle_d = (state_d == ST_IDLE);
  end

  assign sync_o      = sync_q;
  assign bit_o       = bit_q;
  assign bit_valid_o = bit_valid_q;
  assign sof_o       = sof_q;
  assign stuff_err_o = stuff_err_q;
  assign idle_o      = idle_q;

endmodule

// File: tb/tb_can_rx_bit_sampler.sv
// Bench for can_rx_bit_sampler: 50 MHz clock, 1 Mbit bit-clock generator model
// (50 clocks per bit, sample point at clock 35 after restart). Frames are built
// by bit-stuffing a payload; the expected strobe stream is derived from that
// payload and checked by a queue-based monitor.
module tb_can_rx_bit_sampler;

  localparam int BIT_T = 50;
  localparam int SP    = 35;
  localparam int EARLY = 8;

  logic clk_i        = 1'b0;
  logic rst_i        = 1'b1;
  logic can_rx_i     = 1'b1;
  logic can_clk_i    = 1'b1;
  logic destuff_en_i = 1'b1;
  logic rx_done_i    = 1'b0;
  logic sync_o, bit_o, bit_valid_o, sof_o, stuff_err_o, idle_o;

  always #10 clk_i = ~clk_i;

  can_rx_bit_sampler dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .can_rx_i    (can_rx_i),
    .can_clk_i   (can_clk_i),
    .destuff_en_i(destuff_en_i),
    .rx_done_i   (rx_done_i),
    .sync_o      (sync_o),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .sof_o       (sof_o),
    .stuff_err_o (stuff_err_o),
    .idle_o      (idle_o)
  );

  typedef enum int {EV_SYNC, EV_SOF, EV_BIT, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    logic     b;
  } ev_t;

  ev_t  exp_q[$];
  logic pay_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   samp_cnt = 0;
  int   gen_cnt  = 0;
  bit   arm_done = 1'b0;
  bit   req_done = 1'b0;

  // bit-clock generator: restarts on sync_o; also owns rx_done_i timing
  always @(negedge clk_i) begin
    if (rst_i) begin
      gen_cnt   = 0;
      can_clk_i = 1'b1;
      rx_done_i = 1'b0;
    end else begin
      rx_done_i = 1'b0;
      if (req_done) begin
        rx_done_i = 1'b1;
        req_done  = 1'b0;
      end
      if (sync_o) gen_cnt = 0;
      else if (gen_cnt == BIT_T - 1) gen_cnt = 0;
      else gen_cnt++;
      if (can_clk_i && gen_cnt >= SP) begin
        samp_cnt++;
        if (arm_done) begin
          rx_done_i = 1'b1;
          arm_done  = 1'b0;
        end
      end
      can_clk_i = (gen_cnt < SP);
    end
  end

  task automatic check_ev(input ev_kind_e k, input logic b);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL strobe_unexpected: got %s bit=%0b, expected no strobe", k.name(), b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_BIT && e.b != b)) begin
        n_fail++;
        $display("FAIL strobe_order: got %s bit=%0b, expected %s bit=%0b",
                 k.name(), b, e.kind.name(), e.b);
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (sync_o)      check_ev(EV_SYNC, 1'b0);
      if (sof_o)       check_ev(EV_SOF, 1'b0);
      if (bit_valid_o) check_ev(EV_BIT, bit_o);
      if (stuff_err_o) check_ev(EV_ERR, 1'b0);
    end
  end

  task automatic check_val(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
    end
  endtask

  task automatic wait_samples(input int n);
    int t;
    t = samp_cnt + n;
    while (samp_cnt < t) @(negedge clk_i);
  endtask

  task automatic push_ev(input ev_kind_e k, input logic b);
    ev_t e;
    e.kind = k;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic fill_random(input int n, input bit zero_prefix);
    logic v;
    pay_q.delete();
    v = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      if (zero_prefix && i < 4) v = 1'b0;
      else if ($urandom_range(0, 2) == 0) v = ~v;
      pay_q.push_back(v);
    end
  endtask

  // err_mode: 0 none, 1 corrupt first stuff bit, 2 corrupt a random stuff bit
  task automatic run_frame(input int n_tail, input bit early, input int err_mode,
                           input bit done_on_last);
    logic drv[$];
    bit   stf[$];
    bit   off[$];
    int   sidx[$];
    logic run_v;
    int   run_n;
    int   err_at;
    int   last;
    int   len;
    logic b;

    drv.push_back(1'b0); stf.push_back(1'b0); off.push_back(1'b0);
    run_v = 1'b0;
    run_n = 1;
    foreach (pay_q[i]) begin
      if (run_n == 5) begin
        sidx.push_back(drv.size());
        drv.push_back(~run_v); stf.push_back(1'b1); off.push_back(1'b0);
        run_v = ~run_v;
        run_n = 1;
      end
      b = pay_q[i];
      drv.push_back(b); stf.push_back(1'b0); off.push_back(1'b0);
      if (b == run_v) run_n++;
      else begin
        run_v = b;
        run_n = 1;
      end
    end
    for (int i = 0; i < n_tail; i++) begin
      drv.push_back(1'($urandom_range(0, 1))); stf.push_back(1'b0); off.push_back(1'b1);
    end

    err_at = -1;
    if (err_mode != 0 && sidx.size() > 0) begin
      err_at = (err_mode == 1) ? sidx[0] : sidx[$urandom_range(0, sidx.size() - 1)];
      drv[err_at] = drv[err_at - 1];
      while (drv.size() > err_at + 1) begin
        void'(drv.pop_back());
        void'(stf.pop_back());
        void'(off.pop_back());
      end
    end
    if (err_at >= 0) done_on_last = 1'b0;
    last = drv.size() - 1;

    push_ev(EV_SYNC, 1'b0);
    push_ev(EV_SOF, 1'b0);
    for (int j = 1; j <= last; j++) begin
`ifdef CAN_RX_RESYNC_EN
      if (drv[j-1] && !drv[j]) push_ev(EV_SYNC, 1'b0);
`endif
      if (j == err_at) push_ev(EV_ERR, 1'b0);
      else if (!stf[j] && !(done_on_last && j == last)) push_ev(EV_BIT, drv[j]);
    end

    // start the SOF edge well away from a sample point
    len = samp_cnt;
    while (samp_cnt == len) @(negedge clk_i);
    repeat (5) @(negedge clk_i);

    for (int j = 0; j <= last; j++) begin
      len = BIT_T;
      if (early && j < last && drv[j] && !drv[j+1]) len -= EARLY;
      if (early && j > 0 && drv[j-1] && !drv[j]) len += EARLY;
      destuff_en_i = ~off[j];
      can_rx_i     = drv[j];
      if (done_on_last && j == last) arm_done = 1'b1;
      repeat (len) @(negedge clk_i);
    end
    can_rx_i     = 1'b1;
    destuff_en_i = 1'b1;
    if (!done_on_last && err_at < 0) req_done = 1'b1;

    wait_samples(10);
    repeat (3) @(negedge clk_i);
    check_val("idle_after_10_recessive", idle_o, 1'b0);
    wait_samples(1);
    repeat (3) @(negedge clk_i);
    check_val("idle_after_11_recessive", idle_o, 1'b1);
  endtask

  initial begin
    repeat (95000) @(posedge clk_i);
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(negedge clk_i);
    check_val("rst_sync", sync_o, 1'b0);
    check_val("rst_bit_valid", bit_valid_o, 1'b0);
    check_val("rst_sof", sof_o, 1'b0);
    check_val("rst_stuff_err", stuff_err_o, 1'b0);
    check_val("rst_idle", idle_o, 1'b0);
    check_val("rst_bit", bit_o, 1'b0);
    rst_i = 1'b0;

    // idle integration straight out of reset
    wait_samples(10);
    repeat (3) @(negedge clk_i);
    check_val("integ_10_samples", idle_o, 1'b0);
    wait_samples(1);
    repeat (3) @(negedge clk_i);
    check_val("integ_11_samples", idle_o, 1'b1);

    // glitch: hard sync timing, then back to idle without a SOF
    wait_samples(1);
    repeat (5) @(negedge clk_i);
    push_ev(EV_SYNC, 1'b0);
    can_rx_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_val("sync_before_latency", sync_o, 1'b0);
    can_rx_i = 1'b1;
    @(negedge clk_i);
    check_val("sync_at_latency", sync_o, 1'b1);
    check_val("idle_drop_with_sync", idle_o, 1'b0);
    @(negedge clk_i);
    check_val("sync_single_pulse", sync_o, 1'b0);
    wait_samples(1);
    repeat (3) @(negedge clk_i);
    check_val("glitch_back_to_idle", idle_o, 1'b1);

    // SOF, 0000, stuff 1, then 1,0
    pay_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    run_frame(0, 1'b0, 0, 1'b0);

    // run of six dominant bits -> stuff error on the sixth sample
    fill_random(12, 1'b1);
    run_frame(0, 1'b0, 1, 1'b0);

    // early edges mid-bit, and rx_done coincident with the last sample
    pay_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    run_frame(0, 1'b1, 0, 1'b1);

    // destuffing disabled tail with long runs
    pay_q = '{1'b1, 1'b0, 1'b1};
    run_frame(0, 1'b0, 0, 1'b0);
    fill_random(6, 1'b0);
    run_frame(8, 1'b0, 0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      fill_random($urandom_range(6, 22), 1'b0);
      run_frame($urandom_range(0, 5), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
    end

    repeat (100) @(negedge clk_i);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL strobes_missing: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
